// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its cache array.
// Opcode constants, line geometry and the fetch FSM encoding live here.
package inst_fetch_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int WORD_SEL   = 4;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_MISS  = 1'b1;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [WORD_SEL-1:0]  sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped instruction cache storage: valid/tag/data arrays with a
// combinational hit/word read port and a whole-line write port.
module icache_array
    import inst_fetch_pkg::*;
#(
    parameter int LINE_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          rd_addr,
    output logic                 hit,
    output logic [31:0]          rd_word,
    input  logic                 wr_en,
    input  logic [25:0]          wr_addr,
    input  logic [LINE_BITS-1:0] wr_line
);

    localparam int IDX   = $clog2(LINE_NUM);
    localparam int TAG_W = 26 - IDX;

    logic [LINE_NUM-1:0]  valid;
    logic [TAG_W-1:0]     tags [LINE_NUM];
    logic [LINE_BITS-1:0] data [LINE_NUM];

    logic [IDX-1:0]      rd_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [WORD_SEL-1:0] rd_sel;
    logic [IDX-1:0]      wr_idx;
    logic [TAG_W-1:0]    wr_tag;

    // rd_addr is pc[31:2]: word select, then index, then tag
    assign rd_sel = rd_addr[WORD_SEL-1:0];
    assign rd_idx = rd_addr[WORD_SEL +: IDX];
    assign rd_tag = rd_addr[29:WORD_SEL+IDX];
    assign wr_idx = wr_addr[IDX-1:0];
    assign wr_tag = wr_addr[25:IDX];

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_word = line_word(data[rd_idx], rd_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, miss FSM and optional static predictor.
// Define FETCH_PREDICT_EN to enable JAL / backward-branch prediction.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          LINE_NUM = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic [31:0]          rollback_pc,
    input  logic                 issue_full,
    output logic                 inst_config,
    output logic [31:0]          inst_PC,
    input  logic [LINE_BITS-1:0] inst_row,
    input  logic                 inst_out_config,
    output logic                 issue_config,
    output logic [31:0]          issue_inst,
    output logic [31:0]          issue_pc,
    output logic                 issue_pred
);

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] fetch_word;
    logic        hit;
    logic        pred_taken;
    logic        fill_en;

    // inst_PC doubles as the latched miss address, so the fill targets it
    assign fill_en = rdy && (state == ST_MISS) && inst_out_config;

    icache_array #(.LINE_NUM(LINE_NUM)) u_cache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc[31:2]),
        .hit     (hit),
        .rd_word (fetch_word),
        .wr_en   (fill_en),
        .wr_addr (inst_PC[31:6]),
        .wr_line (inst_row)
    );

`ifdef FETCH_PREDICT_EN
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    always_comb begin
        j_imm = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20],
                 fetch_word[30:21], 1'b0};
        b_imm = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25],
                 fetch_word[11:8], 1'b0};
        pred_taken = 1'b0;
        next_pc    = pc + 32'd4;
        if (fetch_word[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc + j_imm;
        end else if (fetch_word[6:0] == OPC_BRANCH && fetch_word[31]) begin
            pred_taken = 1'b1;
            next_pc    = pc + b_imm;
        end
    end
`else
    assign next_pc    = pc + 32'd4;
    assign pred_taken = 1'b0;
`endif

    // Rollback wins over every other action in both states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            inst_config  <= 1'b0;
            inst_PC      <= 32'h0;
            issue_config <= 1'b0;
            issue_inst   <= 32'h0;
            issue_pc     <= 32'h0;
            issue_pred   <= 1'b0;
        end else if (rdy) begin
            issue_config <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (rollback) begin
                        pc <= rollback_pc;
                    end else if (hit) begin
                        if (!issue_full) begin
                            issue_config <= 1'b1;
                            issue_inst   <= fetch_word;
                            issue_pc     <= pc;
                            issue_pred   <= pred_taken;
                            pc           <= next_pc;
                        end
                    end else begin
                        state       <= ST_MISS;
                        inst_config <= 1'b1;
                        inst_PC     <= pc;
                    end
                end
                ST_MISS: begin
                    if (rollback) begin
                        pc <= rollback_pc;
                    end
                    if (rollback || inst_out_config) begin
                        state       <= ST_FETCH;
                        inst_config <= 1'b0;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios then randomized traffic
// against a program-order reference model and a simple mem_ctrl model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         rollback;
    logic [31:0]  rollback_pc;
    logic         issue_full;
    logic         inst_config;
    logic [31:0]  inst_PC;
    logic [511:0] inst_row;
    logic         inst_out_config;
    logic         issue_config;
    logic [31:0]  issue_inst;
    logic [31:0]  issue_pc;
    logic         issue_pred;

    inst_fetch #(.LINE_NUM(16), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback        (rollback),
        .rollback_pc     (rollback_pc),
        .issue_full      (issue_full),
        .inst_config     (inst_config),
        .inst_PC         (inst_PC),
        .inst_row        (inst_row),
        .inst_out_config (inst_out_config),
        .issue_config    (issue_config),
        .issue_inst      (issue_inst),
        .issue_pc        (issue_pc),
        .issue_pred      (issue_pred)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] next;
    } exp_t;

    logic [31:0] mem [1024];
    exp_t        exp_q [$];
    logic [31:0] model_pc;
    int          tests = 0;
    int          fails = 0;
    int          issues_seen = 0;
    bit          mon_en = 0;

    // mem_ctrl model state: 0 = never answer, 1 = answer after lat, 2 = answer now
    int mem_mode = 1;
    bit rand_lat = 0;
    int fixed_lat = 2;
    int lat = 0;
    bit busy = 0;
    bit fill_now = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] build_row(input logic [31:0] addr);
        logic [511:0] r;
        logic [31:0]  a;
        r = '0;
        for (int w = 0; w < 16; w++) begin
            a = {addr[31:6], 6'b0} + 32'(w * 4);
            r[32*w +: 32] = mem[a[11:2]];
        end
        return r;
    endfunction

    // Architectural next-PC rule, computed from immediate field values
    function automatic exp_t model_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem[pc[11:2]];
        e.pred = 1'b0;
        e.next = pc + 32'd4;
`ifdef FETCH_PREDICT_EN
        begin
            int imm;
            if (e.inst[6:0] == 7'b1101111) begin
                imm = (e.inst[31] ? -1048576 : 0) + 32'(e.inst[19:12]) * 4096
                    + 32'(e.inst[20]) * 2048 + 32'(e.inst[30:21]) * 2;
                e.pred = 1'b1;
                e.next = pc + 32'(imm);
            end else if (e.inst[6:0] == 7'b1100011 && e.inst[31]) begin
                imm = -4096 + 32'(e.inst[7]) * 2048 + 32'(e.inst[30:25]) * 32
                    + 32'(e.inst[11:8]) * 2;
                e.pred = 1'b1;
                e.next = pc + 32'(imm);
            end
        end
`endif
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input bit f, input bit rb, input logic [31:0] rbpc);
        @(negedge clk);
        rdy             = r;
        issue_full      = f;
        rollback        = rb;
        rollback_pc     = rbpc;
        inst_out_config = 1'b0;
        fill_now        = 1'b0;
        if (!inst_config) begin
            busy = 1'b0;
        end else if (!busy) begin
            busy = 1'b1;
            lat  = rand_lat ? $urandom_range(0, 4) : fixed_lat;
        end
        if (busy && r && (mem_mode == 2 || (mem_mode == 1 && lat == 0))) begin
            inst_out_config = 1'b1;
            inst_row        = build_row(inst_PC);
            busy            = 1'b0;
            fill_now        = 1'b1;
        end else if (busy && r && mem_mode == 1) begin
            lat--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst             = 1'b0;
        rdy             = 1'b1;
        rollback        = 1'b0;
        issue_full      = 1'b0;
        inst_out_config = 1'b0;
        busy            = 1'b0;
        mon_en          = 1'b1;
        #1;
        check("reset_inst_config", inst_config, 0);
        check("reset_inst_PC", inst_PC, 0);
        check("reset_issue_config", issue_config, 0);
        check("reset_issue_inst", issue_inst, 0);
        check("reset_issue_pc", issue_pc, 0);
        check("reset_issue_pred", issue_pred, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every fresh issue pulse
    initial begin
        logic        e_rdy, e_rb, e_full, e_rst;
        logic [31:0] e_rbpc;
        logic [98:0] snap;
        exp_t        e;
        snap = '0;
        forever begin
            @(posedge clk);
            e_rdy  = rdy;
            e_rb   = rollback;
            e_rbpc = rollback_pc;
            e_full = issue_full;
            e_rst  = rst;
            #1;
            if (!mon_en) begin
            end else if (!e_rst || !rst) begin
                exp_q.delete();
                model_pc = RESET_PC;
            end else if (e_rdy) begin
                if (e_rb || e_full) begin
                    check("stall_no_issue", issue_config, 0);
                end else if (issue_config) begin
                    if (exp_q.size() == 0) begin
                        e = model_fetch(model_pc);
                        exp_q.push_back(e);
                        model_pc = e.next;
                    end
                    e = exp_q.pop_front();
                    check("issue", {issue_pc, issue_inst, issue_pred}, {e.pc, e.inst, e.pred});
                    issues_seen++;
                end
                if (e_rb) begin
                    exp_q.delete();
                    model_pc = e_rbpc;
                end
            end else begin
                check("rdy_low_hold",
                      {issue_config, issue_pc, issue_inst, issue_pred, inst_config, inst_PC}, snap);
            end
            snap = {issue_config, issue_pc, issue_inst, issue_pred, inst_config, inst_PC};
        end
    end

    initial begin
        int          n;
        int          n_issue;
        int          jal_seen;
        logic        jal_pred;
        logic [31:0] held;
        logic [98:0] snap;
        bit          r, f, rb;
        logic [31:0] rbpc;

        rst = 1'b1; rdy = 1'b0; rollback = 1'b0; rollback_pc = '0;
        issue_full = 1'b0; inst_row = '0; inst_out_config = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
        mem[8] = 32'hFF9FF06F;
        for (int i = 256; i < 1024; i++) mem[i] = $urandom;

        // First miss after reset and the fill-to-issue latency
        mem_mode = 1; rand_lat = 0; fixed_lat = 2;
        applyReset();
        @(posedge clk); #1;
        check("first_req_config", inst_config, 1);
        check("first_req_pc", inst_PC, 0);
        n = 0;
        while (!fill_now && n < 20) begin applyStimulus(1, 0, 0, 0); n++; end
        check("fill_seen", fill_now, 1);
        check("fill_cycle_no_issue", issue_config, 0);
        applyStimulus(1, 0, 0, 0);
        check("first_issue_config", issue_config, 1);
        check("first_issue_inst", issue_inst, 32'h13);
        check("first_issue_pc", issue_pc, 0);

        // Sequential hits across line 0, with the JAL at 0x20
        mem_mode = 0; n_issue = 1; jal_seen = 0; jal_pred = 1'b0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 0, 0, 0);
            if (issue_config) begin
                n_issue++;
                if (jal_seen == 1) begin
`ifdef FETCH_PREDICT_EN
                    check("jal_next_pc", issue_pc, 32'h18);
`else
                    check("jal_next_pc", issue_pc, 32'h24);
`endif
                    jal_seen = 2;
                end
                if (issue_pc == 32'h20 && jal_seen == 0) begin
                    jal_pred = issue_pred;
                    jal_seen = 1;
                end
            end
            if (inst_config) break;
        end
        check("jal_reached", jal_seen, 2);
`ifdef FETCH_PREDICT_EN
        check("jal_pred", jal_pred, 1);
        applyStimulus(1, 0, 1, 32'h40);
`else
        check("jal_pred", jal_pred, 0);
        check("seq_issue_count", n_issue, 16);
        check("miss40_config", inst_config, 1);
        check("miss40_pc", inst_PC, 32'h40);
`endif

        // Downstream back-pressure for three cycles
        mem_mode = 1; fixed_lat = 1; n = 0;
        while (!(issue_config && issue_pc == 32'h40) && n < 30) begin applyStimulus(1, 0, 0, 0); n++; end
        check("line40_issue_pc", issue_pc, 32'h40);
        applyStimulus(1, 0, 0, 0);
        held = issue_pc;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 0);
            check("full_no_issue", issue_config, 0);
            check("full_pc_hold", issue_pc, held);
        end
        applyStimulus(1, 0, 0, 0);
        check("full_resume", {issue_config, issue_pc}, {1'b1, held + 32'd4});

        // Rollback during a miss, then rollback coinciding with the fill
        mem_mode = 0;
        applyStimulus(1, 0, 1, 32'h80);
        n = 0;
        while (!inst_config && n < 10) begin applyStimulus(1, 0, 0, 0); n++; end
        check("miss80_req", {inst_config, inst_PC}, {1'b1, 32'h80});
        applyStimulus(1, 0, 1, 32'h100);
        check("rb_drop_config", inst_config, 0);
        n = 0;
        while (!inst_config && n < 10) begin applyStimulus(1, 0, 0, 0); n++; end
        check("rb_new_req", {inst_config, inst_PC}, {1'b1, 32'h100});
        mem_mode = 2;
        applyStimulus(1, 0, 1, 32'h200);
        check("rb_fill_same_cycle", fill_now, 1);
        mem_mode = 0;
        applyStimulus(1, 0, 1, 32'h100);
        applyStimulus(1, 0, 0, 0);
        check("rb_fill_line_hit", {issue_config, issue_pc, inst_config}, {1'b1, 32'h100, 1'b0});

        // Global stall mid-stream
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        snap = {issue_config, issue_pc, issue_inst, issue_pred, inst_config, inst_PC};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0);
            check("rdy_hold_outputs",
                  {issue_config, issue_pc, issue_inst, issue_pred, inst_config, inst_PC}, snap);
        end
        applyStimulus(1, 0, 0, 0);
        check("rdy_resume_pc", {issue_config, issue_pc}, {1'b1, snap[97:66] + 32'd4});

        // Reset while a request is outstanding clears the cache too
        applyStimulus(1, 0, 1, 32'h300);
        n = 0;
        while (!inst_config && n < 10) begin applyStimulus(1, 0, 0, 0); n++; end
        check("miss300_req", {inst_config, inst_PC}, {1'b1, 32'h300});
        applyReset();
        @(posedge clk); #1;
        check("post_reset_req", {inst_config, inst_PC}, {1'b1, 32'h0});

        // Randomized traffic checked by the monitor
        mem_mode = 1; rand_lat = 1;
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 7) != 0);
            f  = ($urandom_range(0, 5) == 0);
            rb = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 7) == 0)
                rbpc = 32'hFFFFFFC0 | (32'($urandom_range(0, 15)) << 2);
            else
                rbpc = 32'($urandom_range(0, 1023)) << 2;
            applyStimulus(r, f, rb, rbpc);
        end
        check("random_progress", issues_seen >= 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
